// File: rtl/data_cache_pkg.sv
// Shared constants and types for the data cache and the reservation stations around it.
// Holds the word size, the miss latency, the unit codes and the cache FSM states.
package data_cache_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int CACHE_MISS_TIME = 10;
  localparam logic [WORD_SIZE-1:0] MAX_UNSIGN_INT = '1;

  localparam logic [1:0] UNIT_ADD   = 2'd0;
  localparam logic [1:0] UNIT_MUL   = 2'd1;
  localparam logic [1:0] UNIT_LOAD  = 2'd2;
  localparam logic [1:0] UNIT_STORE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_FLUSH
  } cache_state_e;

endpackage

// File: rtl/data_cache_if.sv
// Request/response bundle between a reservation station (master) and the data cache (slave).
interface data_cache_if;
  import data_cache_pkg::*;

  logic [WORD_SIZE-1:0] cachein;
  logic                 readable;
  logic                 writable;
  logic [WORD_SIZE-1:0] write;
  logic [WORD_SIZE-1:0] cacheout;
  logic                 miss;
  logic                 flush;
  logic                 busy;

  modport master (output cachein, readable, writable, write, flush,
                  input  cacheout, miss, busy);
  modport slave  (input  cachein, readable, writable, write, flush,
                  output cacheout, miss, busy);
endinterface

// File: rtl/data_mem.sv
// Line-wide backing store with one synchronous read/write port; contents survive reset.
module data_mem #(
  parameter int LINE_W = 128,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [2**AW];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with combinational hits,
// fixed-latency victim writeback / line fill, and a one-line-per-cycle flush.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES        = 64,
  parameter int LINE_WORDS   = 4,
  parameter int MEM_AW       = 12,
  parameter int MISS_LATENCY = CACHE_MISS_TIME
) (
  input  logic         clk,
  input  logic         rst_n,
  data_cache_if.slave  bus
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = MEM_AW - IDX_W - OFF_W;
  localparam int LADDR_W = MEM_AW - OFF_W;
  localparam int LINE_W  = LINE_WORDS * WORD_SIZE;
  localparam int CNT_W   = $clog2(LINES > MISS_LATENCY ? LINES : MISS_LATENCY);

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_hi;

  assign off = bus.cachein[OFF_W-1:0];
  assign idx = bus.cachein[OFF_W +: IDX_W];
  assign tag = bus.cachein[OFF_W+IDX_W +: TAG_W];
  assign unused_addr_hi = ^bus.cachein[WORD_SIZE-1:MEM_AW];

  cache_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [IDX_W-1:0]     req_idx_q, req_idx_d;
  logic [LINES-1:0]     valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES][LINE_WORDS];

  logic req, hit, lat_last, flush_last;

  // Flush wins over a simultaneous request, so that request is reported as a miss.
  assign req        = bus.readable | bus.writable;
  assign hit        = (state_q == ST_IDLE) && !bus.flush && req &&
                      valid_q[idx] && (tag_q[idx] == tag);
  assign lat_last   = (cnt_q == CNT_W'(MISS_LATENCY - 1));
  assign flush_last = (cnt_q == CNT_W'(LINES - 1));

  assign bus.miss     = req && !hit;
  assign bus.cacheout = hit ? data_q[idx][off] : '0;
  assign bus.busy     = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_tag_d = req_tag_q;
    req_idx_d = req_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (req && !hit) begin
          state_d   = (valid_q[idx] && dirty_q[idx]) ? ST_WB : ST_FILL;
          cnt_d     = '0;
          req_tag_d = tag;
          req_idx_d = idx;
        end
      end
      ST_WB: begin
        cnt_d = lat_last ? '0 : cnt_q + 1'b1;
        if (lat_last) state_d = ST_FILL;
      end
      ST_FILL: begin
        cnt_d = lat_last ? '0 : cnt_q + 1'b1;
        if (lat_last) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        cnt_d = flush_last ? '0 : cnt_q + 1'b1;
        if (flush_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writeback source line: the flush cursor while flushing, otherwise the missed index.
  logic [IDX_W-1:0]   wb_idx;
  logic [LINE_W-1:0]  wb_line, mem_rdata;
  logic [LADDR_W-1:0] mem_addr;
  logic               mem_we, wb_phase;

  assign wb_idx   = (state_q == ST_FLUSH) ? cnt_q[IDX_W-1:0] : req_idx_q;
  assign wb_phase = (state_q == ST_WB) || (state_q == ST_FLUSH);
  assign mem_addr = wb_phase ? {tag_q[wb_idx], wb_idx} : {req_tag_q, req_idx_q};
  assign mem_we   = rst_n && (((state_q == ST_WB) && lat_last) ||
                              ((state_q == ST_FLUSH) && dirty_q[wb_idx]));

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wb_line
    assign wb_line[gi*WORD_SIZE +: WORD_SIZE] = data_q[wb_idx][gi];
  end

  data_mem #(.LINE_W(LINE_W), .AW(LADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wb_line),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_tag_q <= req_tag_d;
      req_idx_q <= req_idx_d;
      if (hit && bus.writable) dirty_q[idx] <= 1'b1;
      if ((state_q == ST_FILL) && lat_last) begin
        valid_q[req_idx_q] <= 1'b1;
        dirty_q[req_idx_q] <= 1'b0;
      end
      if (state_q == ST_FLUSH) begin
        valid_q[wb_idx] <= 1'b0;
        dirty_q[wb_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; their valid bits guard them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (hit && bus.writable) data_q[idx][off] <= bus.write;
      if ((state_q == ST_FILL) && lat_last) begin
        tag_q[req_idx_q] <= req_tag_q;
        for (int w = 0; w < LINE_WORDS; w++) begin
          data_q[req_idx_q][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: scoreboarded accesses covering hits, clean/dirty misses,
// aliasing, flush and reset during a fill.
module tb_data_cache;
  import data_cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_if bus ();

  data_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          lat;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; holds the request until miss drops, then releases it.
  task automatic access(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] wdata, input int lat, input logic [31:0] exp_data);
    exp_t e;
    exp_t got;
    int   n;
    e.lat  = lat;
    e.data = exp_data;
    sb_q.push_back(e);
    bus.cachein  = addr;
    bus.readable = rd;
    bus.writable = wr;
    bus.write    = wdata;
    n = 0;
    @(negedge clk);
    while (bus.miss === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    got = sb_q.pop_front();
    check($sformatf("latency addr=0x%03h", addr), n, got.lat);
    check($sformatf("data addr=0x%03h", addr), bus.cacheout, got.data);
    $display("access addr=0x%08h rd=%0d wr=%0d wdata=0x%08h miss_cycles=%0d cacheout=0x%08h",
             addr, rd, wr, wdata, n, bus.cacheout);
    @(posedge clk);
    #1;
    bus.readable = 1'b0;
    bus.writable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.cachein  = '0;
    bus.readable = 1'b0;
    bus.writable = 1'b0;
    bus.write    = '0;
    bus.flush    = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("reset miss", {31'd0, bus.miss}, 32'd0);
    check("reset cacheout", bus.cacheout, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    access(32'h005, 1'b1, 1'b0, 32'd0, 11, 32'd0);

    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("busy after reset", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    access(32'h005, 1'b0, 1'b1, 32'hDEADBEEF, 11, 32'd0);
    access(32'h005, 1'b1, 1'b0, 32'd0, 0, 32'hDEADBEEF);
    access(32'h105, 1'b1, 1'b0, 32'd0, 21, 32'd0);
    access(32'h005, 1'b1, 1'b0, 32'd0, 11, 32'hDEADBEEF);
    access(32'h1005, 1'b0, 1'b1, 32'd7, 0, 32'hDEADBEEF);
    access(32'h005, 1'b1, 1'b0, 32'd0, 0, 32'd7);
    access(32'h005, 1'b1, 1'b1, 32'h12345678, 0, 32'd7);
    access(32'h005, 1'b1, 1'b0, 32'd0, 0, 32'h12345678);
    access(32'h010, 1'b0, 1'b1, 32'h000000A1, 11, 32'd0);
    access(32'h020, 1'b0, 1'b1, 32'h000000B2, 11, 32'd0);
    access(32'h234, 1'b0, 1'b1, 32'h000000C3, 11, 32'd0);

    // Flush together with a read that would otherwise hit.
    bus.flush    = 1'b1;
    bus.cachein  = 32'h010;
    bus.readable = 1'b1;
    @(negedge clk);
    check("flush priority miss", {31'd0, bus.miss}, 32'd1);
    check("busy in flush cycle", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.readable = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("flush busy cycles", n, 32'd64);
    $display("flush busy_cycles=%0d", n);
    @(posedge clk);
    #1;

    access(32'h010, 1'b1, 1'b0, 32'd0, 11, 32'h000000A1);
    access(32'h020, 1'b1, 1'b0, 32'd0, 11, 32'h000000B2);
    access(32'h234, 1'b1, 1'b0, 32'd0, 11, 32'h000000C3);
    access(32'h005, 1'b1, 1'b0, 32'd0, 11, 32'h12345678);

    // Reset in the middle of a line fill.
    bus.cachein  = 32'h300;
    bus.readable = 1'b1;
    repeat (4) @(negedge clk);
    check("busy during fill", {31'd0, bus.busy}, 32'd1);
    check("miss during fill", {31'd0, bus.miss}, 32'd1);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.readable = 1'b0;
    @(posedge clk);
    #1;
    check("busy after fill reset", {31'd0, bus.busy}, 32'd0);
    check("miss after fill reset", {31'd0, bus.miss}, 32'd0);
    rst_n = 1'b1;
    $display("reset during fill applied");
    @(posedge clk);
    #1;

    access(32'h010, 1'b1, 1'b0, 32'd0, 11, 32'h000000A1);
    access(32'h300, 1'b1, 1'b0, 32'd0, 11, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
